// File: rtl/common.sv
// Shared memory-interface types used by every pipeline stage that talks to the data bus.
package common;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-stage control types.
package pipes;

  // DRAIN waits out a bus transaction whose instruction was squashed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } dbus_ctrl_state_t;

endpackage

// File: rtl/dbus_ctrl.sv
// Data-bus controller: registers a memory-stage request onto the bus, holds the
// captured response until the pipeline advances, and counts stall cycles.
module dbus_ctrl
  import common::*;
  import pipes::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t        req_in,
  input  logic             flush,
  input  logic             advance,
  output dbus_req_t        dreq,
  input  dbus_resp_t       dresp,
  output logic             resp_valid,
  output logic [63:0]      resp_data,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  dbus_ctrl_state_t state_q, state_d;
  dbus_req_t        req_q, req_d;
  logic [63:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busActive;
  logic             unusedAddrOk;

  // Address acceptance carries no meaning here; only data_ok ends a transaction.
  assign unusedAddrOk = dresp.addr_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_in.valid && !flush) begin
          req_d   = req_in;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dresp.data_ok) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            data_d  = dresp.data;
            state_d = DONE;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dresp.data_ok) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (advance || flush) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The bus sees the captured request only while a transaction is outstanding.
  always_comb begin
    busActive = (state_q == BUSY) || (state_q == DRAIN);
    dreq      = '0;
    if (busActive) begin
      dreq       = req_q;
      dreq.valid = 1'b1;
    end
  end

  always_comb begin
    stall = req_in.valid && (state_q != DONE) && !flush;
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign resp_valid = (state_q == DONE);
  assign resp_data  = data_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Randomized scoreboard bench for dbus_ctrl: a pipeline driver, a bus responder
// and a response monitor run as separate processes.
module tb_dbus_ctrl;
  import common::*;

  typedef struct {
    dbus_req_t   req;
    int          delay;
    logic [63:0] rdata;
  } busTxn_t;

  logic        clk = 1'b0;
  logic        reset;
  dbus_req_t   req_in, dreq;
  dbus_resp_t  dresp;
  logic        flush, advance, resp_valid, stall;
  logic [63:0] resp_data;
  logic [31:0] stall_cnt;

  dbus_req_t   reqSat, dreqSat;
  dbus_resp_t  respSat;
  logic        respValidSat, stallSat;
  logic [63:0] respDataSat;
  logic [3:0]  stallCntSat;

  int          checks = 0;
  int          failures = 0;
  int unsigned expStallCnt = 0;
  busTxn_t     busQ[$];
  logic [63:0] expQ[$];
  logic        busEnable, busAbort, prevRv;
  dbus_resp_t  forceResp;

  always #5 clk = ~clk;

  dbus_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .flush(flush), .advance(advance),
    .dreq(dreq), .dresp(dresp), .resp_valid(resp_valid), .resp_data(resp_data),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  dbus_ctrl #(.CNT_W(4)) sat (
    .clk(clk), .reset(reset), .req_in(reqSat), .flush(1'b0), .advance(1'b0),
    .dreq(dreqSat), .dresp(respSat), .resp_valid(respValidSat), .resp_data(respDataSat),
    .stall(stallSat), .stall_cnt(stallCntSat)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Acts as the memory system: answers each bus transaction after its planned delay.
  initial begin : responder
    busTxn_t cur;
    bit      active;
    int      cnt;
    active = 0;
    cnt    = 0;
    dresp  = '0;
    forever begin
      @(negedge clk);
      if (busAbort) begin
        active   = 0;
        busAbort = 1'b0;
        busQ.delete();
      end
      dresp = '0;
      if (!busEnable) begin
        dresp     = forceResp;
        forceResp = '0;
      end else if (dreq.valid) begin
        if (!active) begin
          if (busQ.size() == 0) begin
            check("dreq_unexpected", 128'(dreq.valid), 128'(0));
          end else begin
            cur    = busQ.pop_front();
            active = 1;
            cnt    = 0;
            check("dreq_issue", 128'(dreq), 128'(cur.req));
          end
        end else begin
          check("dreq_hold", 128'(dreq), 128'(cur.req));
        end
        if (active) begin
          if (cnt == cur.delay) begin
            dresp.data_ok = 1'b1;
            dresp.data    = cur.rdata;
            active        = 0;
          end else begin
            dresp.addr_ok = ($urandom_range(0, 1) == 1);
            cnt++;
          end
        end
      end else begin
        check("dreq_idle_zero", 128'(dreq), 128'(0));
        if (active) begin
          check("dreq_dropped_early", 128'(0), 128'(1));
          active = 0;
        end
        if ($urandom_range(0, 3) == 0) begin
          dresp.data_ok = 1'b1;
          dresp.data    = {$urandom, $urandom};
        end
      end
    end
  end

  // Pops the scoreboard each time a fresh response is presented.
  initial begin : monitor
    prevRv = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (resp_valid && !prevRv) begin
        if (expQ.size() == 0) begin
          check("resp_unexpected", 128'(resp_valid), 128'(0));
        end else begin
          check("resp_data", 128'(resp_data), 128'(expQ.pop_front()));
        end
      end
      prevRv = resp_valid;
    end
  end

  // One memory-stage instruction: cycle 0 is the first cycle the controller is
  // free to accept it; the bus answers delay cycles after valid first shows.
  task automatic applyStimulus(input logic [31:0] addr, input msize_t size, input logic [7:0] strb,
                               input logic [63:0] wdata, input logic [63:0] rdata,
                               input int delay, input int flushAt, input int hold);
    dbus_req_t r;
    busTxn_t   t;
    int        c, guard;
    bit        expDone, last;
    r.valid = 1'b1; r.addr = addr; r.size = size; r.strobe = strb; r.data = wdata;
    @(negedge clk);
    req_in = r; flush = 1'b0; advance = 1'b0;
    #1;
    guard = 0;
    while (dreq.valid && guard < 200) begin
      check("stall_drain", 128'(stall), 128'(1));
      expStallCnt++;
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 128'(dreq.valid), 128'(0));
    c = 0;
    last = 0;
    while (!last) begin
      expDone = (flushAt < 0) && (c >= delay + 2);
      flush   = (c == flushAt);
      advance = expDone && (c >= delay + 2 + hold);
      if (c == 0 && flushAt != 0) begin
        t.req = r; t.delay = delay; t.rdata = rdata;
        busQ.push_back(t);
      end
      if (c == 0 && flushAt < 0) expQ.push_back(rdata);
      #1;
      check("stall", 128'(stall), 128'(!flush && !expDone));
      if (!flush && !expDone) expStallCnt++;
      check("resp_valid", 128'(resp_valid), 128'(expDone));
      if (expDone) begin
        check("done_resp_data", 128'(resp_data), 128'(rdata));
        check("done_dreq_valid", 128'(dreq.valid), 128'(0));
      end
      last = flush || advance;
      if (!last) begin
        @(negedge clk);
        #1;
      end
      c++;
    end
    check("stall_cnt", 128'(stall_cnt), 128'(expStallCnt));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      req_in       = '0;
      req_in.addr  = $urandom;
      flush        = ($urandom_range(0, 3) == 0);
      advance      = ($urandom_range(0, 1) == 1);
      #1;
      check("stall_idle", 128'(stall), 128'(0));
    end
  endtask

  task automatic checkOutput(input string tag, input logic expDreqValid, input logic expRv);
    check({tag, "_dreq_valid"}, 128'(dreq.valid), 128'(expDreqValid));
    check({tag, "_resp_valid"}, 128'(resp_valid), 128'(expRv));
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    dbus_req_t   r;
    int          d, f;
    logic [63:0] rd;
    req_in = '0; flush = 1'b0; advance = 1'b0; reset = 1'b0;
    busEnable = 1'b1; busAbort = 1'b0; forceResp = '0;
    reqSat = '0; respSat = '0;
    repeat (3) @(negedge clk);
    req_in.valid = 1'b1;
    #1;
    checkOutput("reset", 1'b0, 1'b0);
    check("reset_stall", 128'(stall), 128'(1));
    check("reset_stall_cnt", 128'(stall_cnt), 128'(0));
    check("reset_resp_data", 128'(resp_data), 128'(0));
    check("reset_sat_cnt", 128'(stallCntSat), 128'(0));

    // Saturation instance stalls every cycle from release onwards.
    @(negedge clk);
    req_in = '0; reqSat.valid = 1'b1; reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("sat_cnt_5", 128'(stallCntSat), 128'(5));
    repeat (15) @(negedge clk);
    #1;
    check("sat_cnt_stop", 128'(stallCntSat), 128'(15));
    check("sat_stall", 128'(stallSat), 128'(1));
    check("sat_dreq_valid", 128'(dreqSat.valid), 128'(1));
    check("sat_resp", 128'({respValidSat, respDataSat}), 128'(0));
    check("idle_stall_cnt", 128'(stall_cnt), 128'(0));

    // Directed scenarios: minimum-plus-one load, slow bus, flush in BUSY, held DONE.
    applyStimulus(32'h8000_0010, MSIZE8, 8'hFF, 64'h0, 64'h1122_3344_5566_7788, 1, -1, 0);
    f = int'(expStallCnt);
    applyStimulus(32'h8000_0020, MSIZE4, 8'h0F, 64'h0, 64'hCAFE_F00D_0000_1234, 4, -1, 0);
    check("req034_stall_delta", 128'(stall_cnt - 32'(f)), 128'(6));
    applyStimulus(32'h8000_0030, MSIZE2, 8'h03, 64'h0, 64'h0BAD_0BAD_0BAD_0BAD, 3, 2, 0);
    applyStimulus(32'h8000_0040, MSIZE8, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 0, -1, 3);
    applyStimulus(32'h8000_0048, MSIZE1, 8'h01, 64'h55, 64'h7777_0000_7777_0000, 0, 0, 0);
    applyStimulus(32'h8000_0050, MSIZE4, 8'hF0, 64'hAABB_CCDD_0000_0000, 64'h9, 2, 3, 0);

    for (int i = 0; i < 150; i++) begin
      idleCycles($urandom_range(0, 2));
      d  = $urandom_range(0, 4);
      f  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, d + 1)) : -1;
      rd = {$urandom, $urandom};
      applyStimulus($urandom & 32'hFFFF_FFF8, msize_t'($urandom_range(0, 3)), 8'($urandom),
                    {$urandom, $urandom}, rd, d, f, $urandom_range(0, 2));
    end
    idleCycles(8);
    check("expq_empty", 128'(expQ.size()), 128'(0));
    check("busq_empty", 128'(busQ.size()), 128'(0));
    check("final_stall_cnt", 128'(stall_cnt), 128'(expStallCnt));

    // Reset in the middle of a store; a late data_ok must not produce a response.
    @(negedge clk);
    r.valid = 1'b1; r.addr = 32'h8000_0100; r.size = MSIZE4; r.strobe = 8'h0F; r.data = 64'h1234_5678;
    req_in = r; flush = 1'b0; advance = 1'b0;
    begin
      busTxn_t t;
      t.req = r; t.delay = 1000; t.rdata = 64'hFFFF;
      busQ.push_back(t);
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    busAbort = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_c4", 1'b0, 1'b0);
    check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    req_in = '0; reset = 1'b1;
    busEnable = 1'b0;
    forceResp.data_ok = 1'b1;
    forceResp.data    = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (4) begin
      @(negedge clk);
      #1;
      checkOutput("rst_after", 1'b0, 1'b0);
    end
    check("rst_resp_data", 128'(resp_data), 128'(0));
    check("rst_final_cnt", 128'(stall_cnt), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
